// File: rtl/ring_counter_pkg.sv
// Shared types and constants for the WIDTH-stage ring/Johnson counter.
package ring_counter_pkg;

  typedef enum logic {
    MODE_RING    = 1'b0,
    MODE_JOHNSON = 1'b1
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam int MAX_WIDTH = 64;

  // Reset pattern {0..0,1}; callers truncate to their own WIDTH.
  function automatic logic [MAX_WIDTH-1:0] reset_pattern(input int width);
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    if (width >= 1) r[0] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/ring_counter_n_legal_check.sv
// Combinational legality check: ring codes are one-hot, Johnson codes have
// at most one boundary between adjacent differing bits.
module ring_legal_check
  import ring_counter_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] q,
  input  mode_t            mode,
  output logic             illegal
);

  logic [WIDTH-2:0] diff;
  logic             ring_ok;
  logic             johnson_ok;

  for (genvar i = 0; i < WIDTH - 1; i++) begin : g_diff
    assign diff[i] = q[i] ^ q[i+1];
  end

  assign ring_ok    = (q != '0) && ((q & (q - WIDTH'(1))) == '0);
  assign johnson_ok = ((diff & (diff - (WIDTH-1)'(1))) == '0);
  assign illegal    = (mode == MODE_JOHNSON) ? !johnson_ok : !ring_ok;

endmodule

// File: rtl/ring_counter_n.sv
// Parametrised ring/Johnson counter with load, direction, wrap pulse and
// illegal flag. Define SELF_CORRECT_EN to make a step from an illegal code land on R.
module ring_counter_n
  import ring_counter_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             illegal
);

  localparam logic [WIDTH-1:0] R = WIDTH'(reset_pattern(WIDTH));

  if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("ring_counter_n: WIDTH must be in 2..MAX_WIDTH");
  end

  mode_t            mode_e;
  dir_t             dir_e;
  logic [WIDTH-1:0] q_d, q_q;
  logic             wrap_d, wrap_q;
  logic [WIDTH-1:0] step;
  logic             illegal_w;

  assign mode_e = mode_t'(mode);
  assign dir_e  = dir_t'(dir);

  ring_legal_check #(.WIDTH(WIDTH)) u_legal (
    .q       (q_q),
    .mode    (mode_e),
    .illegal (illegal_w)
  );

  // Johnson is the ring with the wrapped-around bit inverted.
  always_comb begin
    step = q_q;
    if (dir_e == DIR_UP)
      step = {q_q[WIDTH-2:0], q_q[WIDTH-1] ^ (mode_e == MODE_JOHNSON)};
    else
      step = {q_q[0] ^ (mode_e == MODE_JOHNSON), q_q[WIDTH-1:1]};
  end

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (load) begin
      q_d = load_val;
    end else if (en) begin
`ifdef SELF_CORRECT_EN
      if (illegal_w) begin
        q_d = R;
      end else begin
        q_d    = step;
        wrap_d = (step == R);
      end
`else
      q_d    = step;
      wrap_d = (step == R);
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= R;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign q       = q_q;
  assign wrap    = wrap_q;
  assign illegal = illegal_w;

endmodule
